// File: rtl/fft_stream_r2_if.sv
// Sample-in / bin-out stream bundle for fft_stream_r2.
// Output width follows FFT_STAGE_SCALE_EN the same way the core's buffer does.
interface fft_stream_r2_if #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 31
);
  localparam int unsigned LOGN = $clog2(N);
`ifdef FFT_STAGE_SCALE_EN
  localparam int unsigned OW = W + 1;
`else
  localparam int unsigned OW = W + 1 + LOGN;
`endif

  logic                   s_valid;
  logic                   s_ready;
  logic signed [W:0]      s_re;
  logic signed [W:0]      s_im;
  logic                   inverse;
  logic                   m_valid;
  logic                   m_ready;
  logic signed [OW-1:0]   m_re;
  logic signed [OW-1:0]   m_im;
  logic [LOGN-1:0]        m_index;
  logic                   m_last;

  // Source/sink side
  modport master (
    output s_valid, s_re, s_im, inverse, m_ready,
    input  s_ready, m_valid, m_re, m_im, m_index, m_last
  );

  // Core side
  modport slave (
    input  s_valid, s_re, s_im, inverse, m_ready,
    output s_ready, m_valid, m_re, m_im, m_index, m_last
  );
endinterface

// File: rtl/fft_stream_r2.sv
// Streaming iterative radix-2 DIT FFT/IFFT: load N samples bit-reversed, one butterfly per cycle, unload in order.
// Optional FFT_STAGE_SCALE_EN: halve every butterfly output (overall 1/N), buffer/output width W+1.
module fft_stream_r2 #(
  parameter int unsigned N  = 16,
  parameter int unsigned W  = 31,
  parameter int unsigned TW = 18
) (
  input  logic           clk,
  input  logic           rst_n,
  fft_stream_r2_if.slave io,
  output logic           busy
);
  localparam int unsigned LOGN = $clog2(N);
  localparam int unsigned SW   = $clog2(LOGN);
  localparam int unsigned HW   = LOGN - 1;
`ifdef FFT_STAGE_SCALE_EN
  localparam int unsigned BW   = W + 1;
`else
  localparam int unsigned BW   = W + 1 + LOGN;
`endif
  localparam int unsigned PW   = BW + TW + 1;
  localparam int unsigned SH   = TW - 2;
  localparam logic signed [PW-1:0] RND = PW'(1) << (TW - 3);
  localparam real PI  = 3.14159265358979323846;
  localparam real TSC = real'(1 << SH);

  typedef enum logic [1:0] {ST_LOAD, ST_CALC, ST_UNLOAD} state_t;

  state_t               state, state_nx;
  logic [LOGN-1:0]      cnt, cnt_nx;
  logic [SW-1:0]        stg, stg_nx;
  logic [HW-1:0]        bfy, bfy_nx;
  logic                 inv_q, inv_nx;
  logic                 s_ready_q, s_ready_nx;
  logic                 m_valid_q, m_valid_nx;
  logic                 m_last_q, m_last_nx;
  logic                 busy_q, busy_nx;
  logic [LOGN-1:0]      m_index_q, m_index_nx;
  logic signed [BW-1:0] m_re_q, m_re_nx, m_im_q, m_im_nx;

  logic signed [BW-1:0] buf_re [N];
  logic signed [BW-1:0] buf_im [N];

  // Twiddle ROM W_k = exp(-j*2*pi*k/N), Q2.(TW-2), rounded to nearest
  logic signed [TW-1:0] tw_re [N/2];
  logic signed [TW-1:0] tw_im [N/2];
  for (genvar k = 0; k < N/2; k++) begin : g_tw
    localparam real C  = $cos(2.0 * PI * real'(k) / real'(N)) * TSC;
    localparam real S  = -$sin(2.0 * PI * real'(k) / real'(N)) * TSC;
    localparam int  CQ = (C >= 0.0) ? $rtoi(C + 0.5) : -$rtoi(0.5 - C);
    localparam int  SQ = (S >= 0.0) ? $rtoi(S + 0.5) : -$rtoi(0.5 - S);
    assign tw_re[k] = TW'(CQ);
    assign tw_im[k] = TW'(SQ);
  end

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = v[LOGN-1-i];
    return r;
  endfunction

  logic s_acc;
  assign s_acc = io.s_valid && s_ready_q;

  // Butterfly addressing: pair (ia, ia+span), twiddle index pos << (LOGN-1-stg)
  logic [LOGN-1:0] span, lmask, pos, ia, ib;
  logic [HW-1:0]   twi;
  always_comb begin
    span  = LOGN'(1) << stg;
    lmask = span - LOGN'(1);
    pos   = LOGN'(bfy) & lmask;
    ia    = ((LOGN'(bfy) & ~lmask) << 1) | pos;
    ib    = ia | span;
    twi   = HW'(pos << (SW'(LOGN - 1) - stg));
  end

  // Butterfly datapath: t = B*W (conjugated for inverse), A' = A+t, B' = A-t
  logic signed [BW-1:0] a_re, a_im, b_re, b_im;
  logic signed [PW-1:0] w_re, w_im, pr_re, pr_im;
  logic signed [BW+1:0] t_re, t_im, sa_re, sa_im, sb_re, sb_im;
  logic signed [BW+1:0] ha_re, ha_im, hb_re, hb_im;
  logic signed [BW-1:0] na_re, na_im, nb_re, nb_im;
  always_comb begin
    a_re  = buf_re[ia];
    a_im  = buf_im[ia];
    b_re  = buf_re[ib];
    b_im  = buf_im[ib];
    w_re  = PW'(tw_re[twi]);
    w_im  = inv_q ? -PW'(tw_im[twi]) : PW'(tw_im[twi]);
    pr_re = PW'(b_re) * w_re - PW'(b_im) * w_im + RND;
    pr_im = PW'(b_re) * w_im + PW'(b_im) * w_re + RND;
    t_re  = (BW+2)'(pr_re >>> SH);
    t_im  = (BW+2)'(pr_im >>> SH);
    sa_re = (BW+2)'(a_re) + t_re;
    sa_im = (BW+2)'(a_im) + t_im;
    sb_re = (BW+2)'(a_re) - t_re;
    sb_im = (BW+2)'(a_im) - t_im;
`ifdef FFT_STAGE_SCALE_EN
    ha_re = sa_re >>> 1;
    ha_im = sa_im >>> 1;
    hb_re = sb_re >>> 1;
    hb_im = sb_im >>> 1;
`else
    ha_re = sa_re;
    ha_im = sa_im;
    hb_re = sb_re;
    hb_im = sb_im;
`endif
    na_re = BW'(ha_re);
    na_im = BW'(ha_im);
    nb_re = BW'(hb_re);
    nb_im = BW'(hb_im);
  end

  // Sample buffer: bit-reversed loads, in-place butterfly write-back
  always_ff @(posedge clk) begin
    if (state == ST_LOAD && s_acc) begin
      buf_re[bitrev(cnt)] <= BW'(io.s_re);
      buf_im[bitrev(cnt)] <= BW'(io.s_im);
    end else if (state == ST_CALC) begin
      buf_re[ia] <= na_re;
      buf_im[ia] <= na_im;
      buf_re[ib] <= nb_re;
      buf_im[ib] <= nb_im;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    stg_nx     = stg;
    bfy_nx     = bfy;
    inv_nx     = inv_q;
    s_ready_nx = s_ready_q;
    m_valid_nx = m_valid_q;
    m_last_nx  = m_last_q;
    busy_nx    = busy_q;
    m_index_nx = m_index_q;
    m_re_nx    = m_re_q;
    m_im_nx    = m_im_q;
    case (state)
      ST_LOAD: begin
        if (s_acc) begin
          if (cnt == '0) inv_nx = io.inverse;
          cnt_nx = cnt + LOGN'(1);
          if (cnt == LOGN'(N - 1)) begin
            state_nx   = ST_CALC;
            cnt_nx     = '0;
            s_ready_nx = 1'b0;
            busy_nx    = 1'b1;
          end
        end
      end
      ST_CALC: begin
        bfy_nx = bfy + HW'(1);
        if (bfy == '1) begin
          stg_nx = stg + SW'(1);
          if (stg == SW'(LOGN - 1)) begin
            stg_nx     = '0;
            state_nx   = ST_UNLOAD;
            m_valid_nx = 1'b1;
            m_index_nx = '0;
            m_last_nx  = 1'b0;
            m_re_nx    = buf_re[0];
            m_im_nx    = buf_im[0];
          end
        end
      end
      ST_UNLOAD: begin
        if (io.m_ready) begin
          if (cnt == LOGN'(N - 1)) begin
            state_nx   = ST_LOAD;
            cnt_nx     = '0;
            m_valid_nx = 1'b0;
            m_last_nx  = 1'b0;
            busy_nx    = 1'b0;
            s_ready_nx = 1'b1;
          end else begin
            cnt_nx     = cnt + LOGN'(1);
            m_index_nx = cnt + LOGN'(1);
            m_last_nx  = (cnt + LOGN'(1)) == LOGN'(N - 1);
            m_re_nx    = buf_re[cnt + LOGN'(1)];
            m_im_nx    = buf_im[cnt + LOGN'(1)];
          end
        end
      end
      default: state_nx = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      cnt       <= '0;
      stg       <= '0;
      bfy       <= '0;
      inv_q     <= 1'b0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      m_index_q <= '0;
      m_re_q    <= '0;
      m_im_q    <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      stg       <= stg_nx;
      bfy       <= bfy_nx;
      inv_q     <= inv_nx;
      s_ready_q <= s_ready_nx;
      m_valid_q <= m_valid_nx;
      m_last_q  <= m_last_nx;
      busy_q    <= busy_nx;
      m_index_q <= m_index_nx;
      m_re_q    <= m_re_nx;
      m_im_q    <= m_im_nx;
    end
  end

  assign io.s_ready = s_ready_q;
  assign io.m_valid = m_valid_q;
  assign io.m_last  = m_last_q;
  assign io.m_index = m_index_q;
  assign io.m_re    = m_re_q;
  assign io.m_im    = m_im_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_fft_stream_r2.sv
// Testbench for fft_stream_r2: spec-value table, bit-exact FFT reference, handshake and reset sequences.
module tb_fft_stream_r2;
  localparam int N    = 16;
  localparam int W    = 31;
  localparam int TW   = 18;
  localparam int LOGN = 4;
`ifdef FFT_STAGE_SCALE_EN
  localparam bit  SCALED = 1'b1;
  localparam real SCL    = 16.0;
`else
  localparam bit  SCALED = 1'b0;
  localparam real SCL    = 1.0;
`endif
  localparam longint RNDV = longint'(1) << (TW - 3);
  localparam real    ONE  = 65536.0;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_acc = 0;

  fft_stream_r2_if #(.N(N), .W(W)) ifc ();

  fft_stream_r2 #(.N(N), .W(W), .TW(TW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (ifc),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  longint in_re[N], in_im[N], mdl_re[N], mdl_im[N], out_re[N], out_im[N];
  longint twr[N/2], twi[N/2];

  typedef struct {
    int  pat;
    int  bin;
    real re;
    real im;
    int  passes;
    int  tol;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input longint act, input longint exp, input longint tol);
    longint d;
    d = act - exp;
    if (d < 0) d = -d;
    total++;
    if (d > tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  function automatic longint qround(input real s);
    if (s >= 0.0) return longint'($rtoi(s + 0.5));
    return -longint'($rtoi(0.5 - s));
  endfunction

  function automatic int bitrev(input int v);
    int r = 0;
    for (int i = 0; i < LOGN; i++) if (v[i]) r |= 1 << (LOGN - 1 - i);
    return r;
  endfunction

  // Reference radix-2 DIT FFT on plain integer arrays using the stated rounding rules
  task automatic model_fft(input bit inv);
    longint ar[N], ai[N];
    for (int k = 0; k < N; k++) begin
      ar[bitrev(k)] = in_re[k];
      ai[bitrev(k)] = in_im[k];
    end
    for (int s = 0; s < LOGN; s++) begin
      int span;
      span = 1 << s;
      for (int g = 0; g < N; g += 2 * span) begin
        for (int p = 0; p < span; p++) begin
          longint wr, wi, xr, xi, yr, yi, tr, ti, u0r, u0i, u1r, u1i;
          wr  = twr[p * (N / (2 * span))];
          wi  = inv ? -twi[p * (N / (2 * span))] : twi[p * (N / (2 * span))];
          xr  = ar[g + p];        xi = ai[g + p];
          yr  = ar[g + p + span]; yi = ai[g + p + span];
          tr  = (yr * wr - yi * wi + RNDV) >>> (TW - 2);
          ti  = (yr * wi + yi * wr + RNDV) >>> (TW - 2);
          u0r = xr + tr; u0i = xi + ti;
          u1r = xr - tr; u1i = xi - ti;
          if (SCALED) begin
            u0r = u0r >>> 1; u0i = u0i >>> 1; u1r = u1r >>> 1; u1i = u1i >>> 1;
          end
          ar[g + p] = u0r;        ai[g + p] = u0i;
          ar[g + p + span] = u1r; ai[g + p + span] = u1i;
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      mdl_re[k] = ar[k];
      mdl_im[k] = ai[k];
    end
  endtask

  task automatic send_frame(input bit inv, input int gap_pct);
    int guard;
    for (int k = 0; k < N; k++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        ifc.s_valid = 1'b0;
        ifc.inverse = 1'($urandom_range(1));
        @(posedge clk); #1;
      end
      ifc.s_valid = 1'b1;
      ifc.s_re    = (W+1)'(in_re[k]);
      ifc.s_im    = (W+1)'(in_im[k]);
      ifc.inverse = (k == 0) ? inv : !inv;
      guard = 0;
      while (!ifc.s_ready) begin
        @(posedge clk); #1;
        guard++;
        if (guard > 500) begin
          $display("FAIL s_ready timeout: got 0 want 1");
          $fatal(1, "s_ready timeout");
        end
      end
      @(posedge clk); #1;
    end
    ifc.s_valid = 1'b0;
    last_acc = cyc;
  endtask

  task automatic recv_frame(input string tag, input int rdy_pct, input bit use_pat);
    int guard, got, step, lat, p_idx;
    bit calc_ok, hold_ok, last_ok, idx_ok, stall, r, p_last;
    longint p_re, p_im;
    guard = 0; got = 0; step = 0; calc_ok = 1; hold_ok = 1; last_ok = 1; idx_ok = 1; stall = 0;
    p_re = 0; p_im = 0; p_idx = 0; p_last = 0;
    while (!ifc.m_valid) begin
      if (ifc.s_ready || !busy) calc_ok = 0;
      @(posedge clk); #1;
      guard++;
      if (guard > 1000) begin
        $display("FAIL %s m_valid timeout: got 0 want 1", tag);
        $fatal(1, "m_valid timeout");
      end
    end
    lat = cyc - last_acc + 1;
    while (got < N) begin
      if (!ifc.m_valid || ifc.s_ready || !busy) calc_ok = 0;
      if (stall && (longint'(ifc.m_re) != p_re || longint'(ifc.m_im) != p_im ||
                    int'(ifc.m_index) != p_idx || ifc.m_last != p_last)) hold_ok = 0;
      if (ifc.m_last != (int'(ifc.m_index) == N - 1)) last_ok = 0;
      r = use_pat ? ((step % 4) == 0 || (step % 4) == 3) : (int'($urandom_range(99)) < rdy_pct);
      ifc.m_ready = r;
      p_re = longint'(ifc.m_re); p_im = longint'(ifc.m_im);
      p_idx = int'(ifc.m_index); p_last = ifc.m_last;
      stall = !r;
      step++;
      @(posedge clk); #1;
      if (r) begin
        if (p_idx != got) idx_ok = 0;
        out_re[got] = p_re;
        out_im[got] = p_im;
        got++;
      end
      guard++;
      if (guard > 2000) begin
        $display("FAIL %s unload timeout: got %0d bins want %0d", tag, got, N);
        $fatal(1, "unload timeout");
      end
    end
    ifc.m_ready = 1'b0;
    chk({tag, " latency"}, lat, LOGN * N / 2 + 1, 0);
    chk({tag, " sready_low_busy"}, calc_ok, 1, 0);
    chk({tag, " stall_hold"}, hold_ok, 1, 0);
    chk({tag, " mlast_only_15"}, last_ok, 1, 0);
    chk({tag, " index_order"}, idx_ok, 1, 0);
    chk({tag, " mvalid_after"}, ifc.m_valid, 0, 0);
    chk({tag, " sready_after"}, ifc.s_ready, 1, 0);
  endtask

  task automatic run_frame(input string tag, input bit inv, input int gap_pct, input int rdy_pct, input bit use_pat);
    model_fft(inv);
    send_frame(inv, gap_pct);
    recv_frame(tag, rdy_pct, use_pat);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s re[%0d]", tag, k), out_re[k], mdl_re[k], 0);
      chk($sformatf("%s im[%0d]", tag, k), out_im[k], mdl_im[k], 0);
    end
  endtask

  task automatic load_pattern(input int pat);
    for (int k = 0; k < N; k++) begin
      in_im[k] = 0;
      case (pat)
        0: in_re[k] = longint'(k) * 65536;
        1: in_re[k] = (k == 0) ? 65536 : 0;
        2: in_re[k] = 65536;
        default: in_re[k] = longint'(k) * 65536;
      endcase
    end
    if (pat == 3) begin
      model_fft(1'b0);
      for (int k = 0; k < N; k++) begin
        in_re[k] = mdl_re[k];
        in_im[k] = mdl_im[k];
      end
    end
  endtask

  initial begin
    real  ex_re, ex_im, dv;
    ifc.s_valid = 1'b0; ifc.s_re = '0; ifc.s_im = '0; ifc.inverse = 1'b0; ifc.m_ready = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < N / 2; k++) begin
      twr[k] = qround($cos(2.0 * 3.14159265358979323846 * real'(k) / real'(N)) * ONE);
      twi[k] = qround(-$sin(2.0 * 3.14159265358979323846 * real'(k) / real'(N)) * ONE);
    end
    tbl[0]  = '{0, 0,  120.0,  0.0,      1, 128};
    tbl[1]  = '{0, 8,  -8.0,   0.0,      1, 128};
    tbl[2]  = '{0, 1,  -8.0,   40.21872, 1, 128};
    tbl[3]  = '{0, 15, -8.0,  -40.21872, 1, 128};
    tbl[4]  = '{1, 0,  1.0,    0.0,      1, 8};
    tbl[5]  = '{1, 5,  1.0,    0.0,      1, 8};
    tbl[6]  = '{1, 15, 1.0,    0.0,      1, 8};
    tbl[7]  = '{2, 0,  16.0,   0.0,      1, 8};
    tbl[8]  = '{2, 3,  0.0,    0.0,      1, 8};
    tbl[9]  = '{2, 9,  0.0,    0.0,      1, 8};
    tbl[10] = '{3, 1,  16.0,   0.0,      2, 1024};
    tbl[11] = '{3, 7,  112.0,  0.0,      2, 1024};
    tbl[12] = '{3, 15, 240.0,  0.0,      2, 1024};

    #12;
    chk("reset s_ready", ifc.s_ready, 1, 0);
    chk("reset m_valid", ifc.m_valid, 0, 0);
    chk("reset m_last", ifc.m_last, 0, 0);
    chk("reset busy", busy, 0, 0);
    chk("reset m_index", longint'(ifc.m_index), 0, 0);
    chk("reset m_re", longint'(ifc.m_re), 0, 0);
    chk("reset m_im", longint'(ifc.m_im), 0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Spec reference values, each on a fresh frame
    for (int i = 0; i < 13; i++) begin
      load_pattern(tbl[i].pat);
      run_frame($sformatf("tbl%0d", i), tbl[i].pat == 3, 0, 100, 1'b0);
      dv    = (tbl[i].passes == 2) ? SCL * SCL : SCL;
      ex_re = tbl[i].re * ONE / dv;
      ex_im = tbl[i].im * ONE / dv;
      chk($sformatf("tbl%0d bin%0d re", i, tbl[i].bin), out_re[tbl[i].bin], qround(ex_re), tbl[i].tol);
      chk($sformatf("tbl%0d bin%0d im", i, tbl[i].bin), out_im[tbl[i].bin], qround(ex_im), tbl[i].tol);
    end

    // Ramp with input gaps and a 1-0-0-1 ready pattern
    load_pattern(0);
    run_frame("gap_stall", 1'b0, 40, 0, 1'b1);
    chk("gap_stall X0", out_re[0], qround(120.0 * ONE / SCL), 128);

    // Randomized frames against the reference model
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < N; k++) begin
        in_re[k] = longint'($signed($urandom)) >>> 2;
        in_im[k] = longint'($signed($urandom)) >>> 2;
      end
      run_frame($sformatf("rnd%0d", f), 1'($urandom_range(1)), 30, 60, 1'b0);
    end

    // Reset in the middle of CALC, then a clean ramp frame
    load_pattern(0);
    send_frame(1'b0, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("midcalc busy_before", busy, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("midcalc m_valid", ifc.m_valid, 0, 0);
    chk("midcalc busy", busy, 0, 0);
    chk("midcalc s_ready", ifc.s_ready, 1, 0);
    chk("midcalc m_index", longint'(ifc.m_index), 0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    load_pattern(0);
    run_frame("post_reset", 1'b0, 0, 100, 1'b0);
    chk("post_reset X1 im", out_im[1], qround(40.21872 * ONE / SCL), 128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
